// File: rtl/bk_serial_wide_adder_if.sv
// Operand/result handshake bundle for the serial wide Brent-Kung adder.
// The slave modport is the adder side and the master modport is the producer/consumer side.
interface bk_serial_wide_adder_if #(
    parameter int WORDS = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [16*WORDS-1:0]   op_a;
    logic [16*WORDS-1:0]   op_b;
    logic                  op_cin;
    logic                  op_sub;
    logic                  out_valid;
    logic                  out_ready;
    logic [16*WORDS-1:0]   out_sum;
    logic                  out_cout;
    logic                  busy;

    modport master (
        output in_valid, op_a, op_b, op_cin, op_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, busy
    );

    modport slave (
        input  in_valid, op_a, op_b, op_cin, op_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, busy
    );
endinterface

// File: rtl/bk_serial_wide_adder.sv
// Serial wide adder: one 16-bit Brent-Kung slice per clock, LSW first,
// carry held in a register between slices.
module bk_add16 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        cin_i,
    output logic [15:0] sum_o,
    output logic        cout_o
);
    // Carry-in is folded into bit 0's generate, so every prefix includes it
    function automatic logic [16:0] bk16(
        input logic [15:0] a,
        input logic [15:0] b,
        input logic        ci
    );
        logic [15:0] g, p, gg, pp;
        logic [15:0] c;
        g  = a & b;
        p  = a ^ b;
        gg = g;
        pp = p;
        gg[0] = g[0] | (p[0] & ci);
        for (int d = 1; d < 16; d = d * 2) begin
            for (int i = 2 * d - 1; i < 16; i = i + 2 * d) begin
                gg[i] = gg[i] | (pp[i] & gg[i-d]);
                pp[i] = pp[i] & pp[i-d];
            end
        end
        for (int d = 4; d >= 1; d = d / 2) begin
            for (int i = 3 * d - 1; i < 16; i = i + 2 * d) begin
                gg[i] = gg[i] | (pp[i] & gg[i-d]);
                pp[i] = pp[i] & pp[i-d];
            end
        end
        c = {gg[14:0], ci};
        return {gg[15], p ^ c};
    endfunction

    logic [16:0] res;

    always_comb begin
        res = bk16(a_i, b_i, cin_i);
    end

    assign sum_o  = res[15:0];
    assign cout_o = res[16];
endmodule

module bk_serial_wide_adder #(
    parameter int WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    bk_serial_wide_adder_if.slave   bus
);
    localparam int W  = 16 * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   idx_q;
    logic            carry_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    sum_q;
    logic            cout_q;
    logic            valid_q;

    logic [15:0]     slice_a_d;
    logic [15:0]     slice_b_d;
    logic [15:0]     slice_sum_d;
    logic            slice_cout_d;

    always_comb begin
        slice_a_d = a_q[16*idx_q +: 16];
        slice_b_d = b_q[16*idx_q +: 16];
    end

    bk_add16 u_bk (
        .a_i    (slice_a_d),
        .b_i    (slice_b_d),
        .cin_i  (carry_q),
        .sum_o  (slice_sum_d),
        .cout_o (slice_cout_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.op_a;
                        b_q     <= bus.op_sub ? ~bus.op_b : bus.op_b;
                        carry_q <= bus.op_sub | bus.op_cin;
                        idx_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q[16*idx_q +: 16] <= slice_sum_d;
                    carry_q <= slice_cout_d;
                    if (idx_q == LAST) begin
                        idx_q   <= '0;
                        cout_q  <= slice_cout_d;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE) & ~rst;
    assign bus.out_valid = valid_q;
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;
    assign bus.busy      = (state_q != IDLE);
endmodule
